// File: rtl/audio_pkg.sv
// Shared fixed-point definitions for the audio decimator: Q-format widths,
// saturation limits and the Q1.23 -> Q2.10 round/saturate helper.
package audio_pkg;

    // Input format: signed Q1.23.
    localparam int in_frac_lp  = 23;

    // Output format: signed Q2.10 (12 bits total).
    localparam int int_out_lp  = 2;
    localparam int frac_out_lp = 10;
    localparam int out_w_lp    = int_out_lp + frac_out_lp;

    // LSBs dropped when going from the input grid to the output grid.
    localparam int drop_lp     = in_frac_lp - frac_out_lp;

    // Working width for the gained average. Must hold width_in_p plus the
    // largest legal gain shift (24 + 4) with margin for the rounding add.
    localparam int calc_w_lp   = 40;

    // Half an output LSB expressed on the input grid (round half toward +inf).
    localparam logic signed [calc_w_lp-1:0] round_k_lp = calc_w_lp'(1) << (drop_lp - 1);

    // Output saturation limits, in output format and widened to the working width.
    localparam logic signed [out_w_lp-1:0]  sat_max_lp   = 12'sh7FF;
    localparam logic signed [out_w_lp-1:0]  sat_min_lp   = 12'sh800;
    localparam logic signed [calc_w_lp-1:0] sat_max_w_lp = calc_w_lp'(sat_max_lp);
    localparam logic signed [calc_w_lp-1:0] sat_min_w_lp = calc_w_lp'(sat_min_lp);

    // Rounded/saturated output sample plus a flag saying the limit was hit.
    typedef struct packed {
        logic signed [out_w_lp-1:0] q;
        logic                       sat;
    } q_res_t;

    // Round a Q1.23 value (sign-extended to calc_w_lp) to Q2.10 and clamp it.
    function automatic q_res_t round_sat_q(input logic signed [calc_w_lp-1:0] g);
        logic signed [calc_w_lp-1:0] rounded;
        q_res_t                      res;
        rounded = (g + round_k_lp) >>> drop_lp;
        res.sat = 1'b0;
        if (rounded > sat_max_w_lp) begin
            res.q   = sat_max_lp;
            res.sat = 1'b1;
        end else if (rounded < sat_min_w_lp) begin
            res.q   = sat_min_lp;
            res.sat = 1'b1;
        end else begin
            res.q   = rounded[out_w_lp-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_decimator_out_reg.sv
// Single-entry valid/ready output register for the decimator. Holds its
// sample stable while stalled and tracks the sticky saturation flag.
module decim_out_reg
    import audio_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       load_i,
    input  logic signed [out_w_lp-1:0] data_i,
    input  logic                       sat_i,
    input  logic                       ready_i,
    output logic signed [out_w_lp-1:0] data_o,
    output logic                       valid_o,
    output logic                       sat_o
);

    logic signed [out_w_lp-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       sat_q, sat_d;

    // Next-state: load wins over transfer so a same-cycle replace has no bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        data_d  = data_q;
        valid_d = valid_q;
        sat_d   = sat_q;
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
            sat_d   = sat_q | sat_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State register; the data word is reset too because data_o=0 is visible in reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/audio_decimator.sv
// Boxcar decimator for the note tuner: averages groups of 2^decim_log2_p
// Q1.23 samples, applies a power-of-two gain, rounds and saturates to Q2.10,
// and presents the result on a valid/ready output.
module audio_decimator
    import audio_pkg::*;
#(
    parameter int width_in_p   = 24,
    parameter int decim_log2_p = 2,
    parameter int gain_shift_p = 0
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic signed [width_in_p-1:0]            data_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    output logic signed [int_out_lp-1:-frac_out_lp] data_o,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic                                    sat_o
);

    // Accumulator is wide enough for N full-scale samples, so it never overflows.
    localparam int acc_w_lp = width_in_p + decim_log2_p;
    // Keep at least one counter bit so decim_log2_p=0 still elaborates; the
    // counter then sits at 0, which is also the last index.
    localparam int cnt_w_lp = (decim_log2_p > 0) ? decim_log2_p : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'((1 << decim_log2_p) - 1);

    logic signed [acc_w_lp-1:0]  acc_q, acc_d;
    logic        [cnt_w_lp-1:0]  cnt_q, cnt_d;

    logic signed [acc_w_lp-1:0]  sum;
    logic signed [acc_w_lp-1:0]  avg;
    logic signed [calc_w_lp-1:0] gained;
    q_res_t                      res;

    logic                        last_cnt;
    logic                        accept;
    logic                        load;
    logic signed [out_w_lp-1:0]  out_data;
    logic                        out_valid;

    // Datapath: group sum including the current sample, average, gain, round/saturate.
    always_comb begin
        sum    = acc_q + acc_w_lp'(data_i);
        avg    = sum >>> decim_log2_p;
        gained = calc_w_lp'(avg) <<< gain_shift_p;
        res    = round_sat_q(gained);
    end

    // Handshake and accumulator/counter next-state. Only the group-completing
    // sample is refused while the output is stalled, and ready_o never looks at valid_i.
    always_comb begin
        last_cnt = (cnt_q == cnt_last_lp);
        ready_o  = !(out_valid && !ready_i && last_cnt);
        accept   = valid_i && ready_o;
        load     = accept && last_cnt;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept) begin
            if (last_cnt) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Accumulator and sample counter; a reset mid-group discards the partial sum.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    decim_out_reg u_out_reg (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (load),
        .data_i   (res.q),
        .sat_i    (res.sat),
        .ready_i  (ready_i),
        .data_o   (out_data),
        .valid_o  (out_valid),
        .sat_o    (sat_o)
    );

    assign data_o  = out_data;
    assign valid_o = out_valid;

endmodule

// File: doc/audio_decimator.md
Name: audio_decimator

Overview:
Upstream conditioning stage for the note tuner. Takes raw signed line-in samples (Q1.23, 24-bit) and block-averages groups of 2^decim_log2_p samples (boxcar decimation), then applies a power-of-two gain. It rounds and saturates the result to the tuner's Q2.10 audio format and presents it on a valid/ready output that drives the tuner's audio/valid inputs.

Parameters:
width_in_p, 24, input sample width; signed Q1.23 (range [-1,1))
decim_log2_p, 2, log2 of decimation ratio N; legal 0..6
gain_shift_p, 0, left-shift gain applied after averaging; legal 0..4
int_out_lp, 2, integer bits of output (incl. sign)
frac_out_lp, 10, fractional bits of output

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
data_i  in  width_in_p  signed Q1.23 input sample
valid_i  in  1  data_i valid
ready_o  out  1  block can accept data_i this cycle
data_o  out  [int_out_lp-1:-frac_out_lp]  signed Q2.10 decimated sample
valid_o  out  1  data_o valid
ready_i  in  1  downstream accepts data_o
sat_o  out  1  sticky: some output sample saturated since reset

Behaviour:
- Clock clk_i; reset_ni is asynchronous and active-low. While reset_ni=0: acc=0, cnt=0, valid_o=0, data_o=0, sat_o=0, ready_o=1.
- Input accept: valid_i && ready_o. Output transfer: valid_o && ready_i.
- Accumulator: signed, width_in_p+decim_log2_p bits, sign-extended add; cannot overflow.
- cnt: decim_log2_p-bit sample counter. Increments on each accept and wraps N-1 -> 0. On the accept where cnt==N-1 ("last accept"), the completed sum (acc + data_i) goes to the output stage and acc clears to 0 on that same edge. The next group starts cleanly with no sample lost.
- Arithmetic, in order:
  1. avg = sum >>> decim_log2_p (arithmetic shift).
  2. g = avg << gain_shift_p, computed at full width with no loss.
  3. Convert Q1.23 to Q2.10: add rounding constant 2^12 (half output LSB, round half toward +inf), then drop 13 LSBs.
  4. Saturate to 12-bit signed range [0x800, 0x7FF].
- sat_o sets when a saturated value loads into data_o. It clears only on reset.
- Output register: loads on the last accept when the register is empty or being transferred that cycle. valid_o rises on the cycle after the last accept, so latency is 1 cycle from the final sample of a group. data_o and valid_o hold stable while valid_o && !ready_i.
- Backpressure: ready_o = !(valid_o && !ready_i && cnt==N-1).
  - Accumulation of a new group continues while output is stalled.
  - Only the completing sample is refused.
  - ready_o is combinational from valid_o, ready_i and cnt, with no path from valid_i.
- Simultaneous last accept and output transfer in the same cycle: the new result replaces the old one, valid_o stays 1, and no bubble occurs.
- decim_log2_p=0: every accept is a last accept, giving a pass-through with rounding, saturation and gain.
- Reset asserted mid-group: the partial sum is discarded and counting restarts at cnt=0.

Decomposition:
- Shared package audio_pkg:
  - Q-format constants (in frac bits 23, out int 2 / frac 10).
  - Saturation limits.
  - Function round_sat_q(), which performs round + saturate to Q2.10.
- One natural sub-module, decim_out_reg: the single-entry valid/ready output register with hold-under-stall. The accumulator, counter and ready logic stay in the top module.

Test Plan:
- Defaults, ready_i=1, 4 samples of 0x400000 (0.5) -> one output data_o=0x200 one cycle after the 4th accept; sat_o=0.
- 4 samples of 0x800000 (-1.0) -> data_o=0xC00. Samples {0x001000 x4} -> 0x001. Samples {0x000FFF x4} -> 0x000. Samples {0xFFF000 x4} -> 0x000 (round half toward +inf).
- gain_shift_p=2, 4 samples 0x600000 (0.75) -> data_o=0x7FF, sat_o=1 and sticky. Next group 0x000000 -> data_o=0x000 with sat_o still 1.
- Backpressure: ready_i=0 after first output; offer 8 more samples -> 3 accepted, ready_o=0 on the 4th with valid_i held. Raise ready_i -> first output transfers, 4th sample accepted same cycle, next output appears, and no sample is lost or duplicated (check via sequential ramp input).
- Random valid_i/ready_i (50%) on a ramp 0..255 (scaled <<12) -> output stream matches the reference model of group averages in order.
- Assert reset_ni=0 asynchronously (mid-cycle) after 2 of 4 samples -> valid_o=0, data_o=0, ready_o=1 immediately. After release, 4 samples of 0x400000 -> exactly one output of 0x200.
